// File: rtl/pc_fetch_gen_pkg.sv
// pc_fetch_gen_pkg: shared widths, FSM state encoding and word-align helper for the fetch PC generator
package pc_fetch_gen_pkg;
    localparam int          DATA_W      = 32;
    localparam logic [31:0] PC_STEP_DEF = 32'd4;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_fetch_gen_if.sv
// pc_fetch_gen_if: redirect/stall/halt requests in, fetch address and status out
interface pc_fetch_gen_if;
    import pc_fetch_gen_pkg::*;

    logic              branch_taken_i;
    logic [DATA_W-1:0] branch_tgt_i;
    logic              stall_i;
    logic              halt_i;
    logic [DATA_W-1:0] pc_o;
    logic [DATA_W-1:0] pc_plus4_o;
    logic              pc_valid_o;
    logic              misalign_o;
    logic              halted_o;
    logic [DATA_W-1:0] fetch_cnt_o;

    modport master (
        output branch_taken_i, branch_tgt_i, stall_i, halt_i,
        input  pc_o, pc_plus4_o, pc_valid_o, misalign_o, halted_o, fetch_cnt_o
    );

    modport slave (
        input  branch_taken_i, branch_tgt_i, stall_i, halt_i,
        output pc_o, pc_plus4_o, pc_valid_o, misalign_o, halted_o, fetch_cnt_o
    );
endinterface

// File: rtl/pc_fetch_gen_pc_next_sel.sv
// pc_next_sel: combinational next-PC mux (redirect > hold > sequential) and redirect misalign detect
module pc_next_sel
    import pc_fetch_gen_pkg::*;
#(
    parameter logic [DATA_W-1:0] PC_STEP = PC_STEP_DEF
) (
    input  state_e            state_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              branch_taken_i,
    input  logic [DATA_W-1:0] branch_tgt_i,
    input  logic              stall_i,
    input  logic              halt_i,
    output logic [DATA_W-1:0] pc_next_o,
    output logic [DATA_W-1:0] pc_plus_o,
    output logic              misalign_next_o
);
    logic active;
    logic redirect;
    logic advance;

    // Redirect wins over halt and stall; otherwise only an unstalled, unhalted fetch advances
    always_comb begin
        active          = (state_i == S_FETCH) || (state_i == S_STALL);
        redirect        = active && branch_taken_i;
        advance         = active && !branch_taken_i && !halt_i && !stall_i;
        pc_plus_o       = pc_i + PC_STEP;
        pc_next_o       = redirect ? align_word(branch_tgt_i) : advance ? pc_plus_o : pc_i;
        misalign_next_o = redirect && (|branch_tgt_i[1:0]);
    end
endmodule

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: fetch-stage PC register and control FSM; optional retired-fetch counter under FETCH_CNT_EN
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [DATA_W-1:0] PC_STEP      = PC_STEP_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_fetch_gen_if.slave bus
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;
    logic [DATA_W-1:0] pc_plus;

    pc_next_sel #(.PC_STEP(PC_STEP)) u_sel (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .branch_taken_i  (bus.branch_taken_i),
        .branch_tgt_i    (bus.branch_tgt_i),
        .stall_i         (bus.stall_i),
        .halt_i          (bus.halt_i),
        .pc_next_o       (pc_d),
        .pc_plus_o       (pc_plus),
        .misalign_next_o (misalign_d)
    );

    // Next state: leave reset once, then redirect > halt > stall > run; halt is sticky until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:          state_d = S_FETCH;
            S_FETCH, S_STALL: state_d = bus.branch_taken_i ? S_FETCH :
                                        bus.halt_i         ? S_HALT  :
                                        bus.stall_i        ? S_STALL : S_FETCH;
            default:          state_d = S_HALT;
        endcase
    end

    // State, PC and misalign pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_plus;
    assign bus.pc_valid_o = (state_q == S_FETCH) || (state_q == S_STALL);
    assign bus.misalign_o = misalign_q;
    assign bus.halted_o   = (state_q == S_HALT);

`ifdef FETCH_CNT_EN
    logic [DATA_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic              count_en;

    // A fetch retires on any running edge that is neither stalled nor redirected
    always_comb begin
        count_en    = ((state_q == S_FETCH) || (state_q == S_STALL)) && !bus.stall_i && !bus.branch_taken_i;
        fetch_cnt_d = fetch_cnt_q + {{(DATA_W-1){1'b0}}, count_en};
    end

    // Retired-fetch counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_cnt_q <= '0;
        else        fetch_cnt_q <= fetch_cnt_d;
    end

    assign bus.fetch_cnt_o = fetch_cnt_q;
`else
    assign bus.fetch_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen: directed vectors with a queue-based scoreboard for pc_fetch_gen
module tb_pc_fetch_gen;
    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        logic        halt;
        logic [31:0] cnt;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    logic [31:0] ec = '0;

    pc_fetch_gen_if bus();

    pc_fetch_gen #(.RESET_VECTOR(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, req);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef FETCH_CNT_EN
        return c;
`else
        return c & 32'h0;
`endif
    endfunction

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", bus.pc_o, e.pc);
            chk("pc_plus4", bus.pc_plus4_o, e.pc + 32'd4);
            chk("pc_valid", {31'd0, bus.pc_valid_o}, {31'd0, e.valid});
            chk("misalign", {31'd0, bus.misalign_o}, {31'd0, e.mis});
            chk("halted", {31'd0, bus.halted_o}, {31'd0, e.halt});
            chk("fetch_cnt", bus.fetch_cnt_o, e.cnt);
        end
    end

    task automatic step(input logic rn, input logic br, input logic [31:0] tgt, input logic st,
                        input logic hl, input logic [31:0] pc, input logic v, input logic m,
                        input logic h, input logic inc);
        exp_t e;
        ec = rn ? ec + {31'd0, inc} : 32'd0;
        e.pc = pc; e.valid = v; e.mis = m; e.halt = h; e.cnt = cnt_exp(ec);
        q.push_back(e);
        rst_n = rn;
        bus.branch_taken_i = br;
        bus.branch_tgt_i = tgt;
        bus.stall_i = st;
        bus.halt_i = hl;
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.branch_taken_i = 1'b0;
        bus.branch_tgt_i = '0;
        bus.stall_i = 1'b0;
        bus.halt_i = 1'b0;
        #1;
        //    rn br tgt           st hl  pc            v  m  h  inc
        step(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0);
        step(1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0);
        step(1, 0, 32'h0,        0, 0, 32'h4,        1, 0, 0, 1);
        step(1, 0, 32'h0,        0, 0, 32'h8,        1, 0, 0, 1);
        step(1, 0, 32'h0,        1, 0, 32'h8,        1, 0, 0, 0);
        step(1, 0, 32'h0,        1, 0, 32'h8,        1, 0, 0, 0);
        step(1, 0, 32'h0,        1, 0, 32'h8,        1, 0, 0, 0);
        step(1, 0, 32'h0,        0, 0, 32'hC,        1, 0, 0, 1);
        step(1, 0, 32'h0,        0, 0, 32'h10,       1, 0, 0, 1);
        step(1, 1, 32'h40,       1, 0, 32'h40,       1, 0, 0, 0);
        step(1, 0, 32'h0,        0, 0, 32'h44,       1, 0, 0, 1);
        step(1, 0, 32'h0,        1, 0, 32'h44,       1, 0, 0, 0);
        step(1, 1, 32'h42,       0, 0, 32'h40,       1, 1, 0, 0);
        step(1, 0, 32'h0,        0, 0, 32'h44,       1, 0, 0, 1);
        step(1, 1, 32'h20,       0, 0, 32'h20,       1, 0, 0, 0);
        step(1, 0, 32'h0,        1, 1, 32'h20,       0, 0, 1, 0);
        step(1, 1, 32'h80,       1, 0, 32'h20,       0, 0, 1, 0);
        step(1, 0, 32'h0,        0, 0, 32'h20,       0, 0, 1, 0);
        step(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0);
        step(1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0);
        step(1, 0, 32'h0,        0, 0, 32'h4,        1, 0, 0, 1);
        step(1, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 1, 0, 0, 0);
        step(1, 0, 32'h0,        0, 0, 32'hFFFF_FFFC, 1, 0, 0, 1);
        step(1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 1);
        step(1, 0, 32'h0,        0, 0, 32'h4,        1, 0, 0, 1);
        step(1, 0, 32'h0,        0, 1, 32'h4,        0, 0, 1, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        ec = '0;
        #1;
        chk("async_pc", bus.pc_o, 32'h0);
        chk("async_valid", {31'd0, bus.pc_valid_o}, 32'd0);
        chk("async_halted", {31'd0, bus.halted_o}, 32'd0);
        chk("async_misalign", {31'd0, bus.misalign_o}, 32'd0);
        chk("async_cnt", bus.fetch_cnt_o, 32'd0);
        @(negedge clk);
        #1;
        step(1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0);
        step(1, 1, 32'h7,        0, 0, 32'h4,        1, 1, 0, 0);
        step(1, 1, 32'h3,        1, 1, 32'h0,        1, 1, 0, 0);
        step(1, 0, 32'h0,        0, 0, 32'h4,        1, 0, 0, 1);
        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
